// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: pin synchronisers, clock glitch filter, 11-bit framing, E0/F0 prefix
// decode and held-key flags. Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_key_decoder #(
  parameter int                    SYNC_STAGES = 2,
  parameter int                    FILT_LEN    = 4,
  parameter int                    TIMEOUT_CYC = 50000,
  parameter int                    NUM_KEYS    = 2,
  parameter logic [NUM_KEYS*8-1:0] KEY_CODES   = {8'h75, 8'h72}
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                PS2_CLK_in,
  input  logic                PS2_DAT_in,
  output logic [7:0]          code_out,
  output logic                code_valid,
  output logic                code_break,
  output logic                code_ext,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                frame_err
);

  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

`ifdef PS2_PARITY_CHECK_EN
  localparam logic PAR_CHECK = 1'b1;
`else
  localparam logic PAR_CHECK = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] dat_sync_r;
  logic                   clk_s;
  logic                   dat_s;
  logic                   filt_r;
  logic [FW-1:0]          filt_cnt_r;
  logic                   fall_s;
  logic                   timeout_s;
  logic [TW-1:0]          to_cnt_r;
  logic [1:0]             state_r;
  logic [2:0]             bit_cnt_r;
  logic [7:0]             shift_r;
  logic                   par_r;
  logic                   accept_r;
  logic                   ext_pend_r;
  logic                   brk_pend_r;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    odd_parity_ok = ^{data, par};
  endfunction

  assign clk_s = clk_sync_r[SYNC_STAGES-1];
  assign dat_s = dat_sync_r[SYNC_STAGES-1];

  // Fall strobe and mid-frame timeout detection.
  always_comb begin
    fall_s    = 1'b0;
    timeout_s = 1'b0;
    if (filt_r && !clk_s && (filt_cnt_r == FW'(FILT_LEN - 1))) begin
      fall_s = 1'b1;
    end else begin
      fall_s = 1'b0;
    end
    if ((state_r != ST_IDLE) && !fall_s && (to_cnt_r == TW'(TIMEOUT_CYC - 1))) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Pin synchronisers; the idle bus level is high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_r <= {SYNC_STAGES{1'b1}};
      dat_sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], PS2_CLK_in};
      dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], PS2_DAT_in};
    end
  end

  // Filtered clock flips only after FILT_LEN consecutive samples that disagree with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt_r     <= 1'b1;
      filt_cnt_r <= {FW{1'b0}};
    end else if (clk_s == filt_r) begin
      filt_cnt_r <= {FW{1'b0}};
    end else if (filt_cnt_r == FW'(FILT_LEN - 1)) begin
      filt_r     <= clk_s;
      filt_cnt_r <= {FW{1'b0}};
    end else begin
      filt_cnt_r <= filt_cnt_r + FW'(1);
    end
  end

  // Idle-time counter, restarted by every fall while a frame is open.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt_r <= {TW{1'b0}};
    end else if (fall_s || (state_r == ST_IDLE)) begin
      to_cnt_r <= {TW{1'b0}};
    end else begin
      to_cnt_r <= to_cnt_r + TW'(1);
    end
  end

  // Frame FSM: start, 8 data bits LSB first, parity, stop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      par_r     <= 1'b0;
      accept_r  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      accept_r  <= 1'b0;
      frame_err <= 1'b0;
      if (timeout_s) begin
        state_r   <= ST_IDLE;
        frame_err <= 1'b1;
      end else if (fall_s) begin
        case (state_r)
          ST_IDLE: begin
            if (!dat_s) begin
              state_r   <= ST_DATA;
              bit_cnt_r <= 3'd0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          ST_DATA: begin
            shift_r   <= {dat_s, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= ST_PARITY;
            end else begin
              state_r <= ST_DATA;
            end
          end
          ST_PARITY: begin
            par_r   <= dat_s;
            state_r <= ST_STOP;
          end
          ST_STOP: begin
            if (dat_s && (!PAR_CHECK || odd_parity_ok(shift_r, par_r))) begin
              accept_r <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state_r <= ST_IDLE;
          end
          default: state_r <= ST_IDLE;
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  // Prefix tracking, code strobe and held-key flags, one cycle after acceptance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      code_out   <= 8'h00;
      code_valid <= 1'b0;
      code_break <= 1'b0;
      code_ext   <= 1'b0;
      key_held   <= {NUM_KEYS{1'b0}};
      ext_pend_r <= 1'b0;
      brk_pend_r <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      if (accept_r) begin
        case (shift_r)
          8'hE0: ext_pend_r <= 1'b1;
          8'hF0: brk_pend_r <= 1'b1;
          default: begin
            code_valid <= 1'b1;
            code_out   <= shift_r;
            code_break <= brk_pend_r;
            code_ext   <= ext_pend_r;
            ext_pend_r <= 1'b0;
            brk_pend_r <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
              if (shift_r == KEY_CODES[8*i +: 8]) begin
                key_held[i] <= !brk_pend_r;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder (short timeout for simulation speed).
module tb_ps2_key_decoder;
  localparam int T_OUT   = 300;
  localparam int DET_LAT = 6;   // pin fall to detected fall: 2 sync flops + 4 filter samples

  logic       clock = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] code_out;
  logic       code_valid;
  logic       code_break;
  logic       code_ext;
  logic [1:0] key_held;
  logic       frame_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int cv_cnt   = 0;
  int fe_cnt   = 0;
  int cv_cyc   = 0;
  int fe_cyc   = 0;
  int drop_cyc = 0;
  logic [7:0] cv_code;
  logic       cv_brk;
  logic       cv_ext;
  logic [1:0] cv_keys;

  ps2_key_decoder #(.TIMEOUT_CYC(T_OUT)) dut (
    .clock(clock), .reset(reset), .PS2_CLK_in(ps2_clk), .PS2_DAT_in(ps2_dat),
    .code_out(code_out), .code_valid(code_valid), .code_break(code_break),
    .code_ext(code_ext), .key_held(key_held), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (code_valid) begin
      cv_cnt  <= cv_cnt + 1;
      cv_cyc  <= cyc;
      cv_code <= code_out;
      cv_brk  <= code_break;
      cv_ext  <= code_ext;
      cv_keys <= key_held;
    end
    if (frame_err) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
  end

  function automatic logic [10:0] mk(input logic [7:0] b, input logic bad_par, input logic stop);
    mk = {stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n, input logic glitch);
    for (int i = 0; i < n; i++) begin
      ps2_dat = bits[i];
      repeat (10) @(negedge clock);
      if (glitch) begin
        ps2_clk = 1'b0; @(negedge clock); ps2_clk = 1'b1;
        repeat (5) @(negedge clock);
      end else begin
        repeat (6) @(negedge clock);
      end
      ps2_clk  = 1'b0;
      drop_cyc = cyc;
      repeat (10) @(negedge clock);
      if (glitch) begin
        ps2_clk = 1'b1; @(negedge clock); ps2_clk = 1'b0;
        repeat (5) @(negedge clock);
      end else begin
        repeat (6) @(negedge clock);
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    repeat (32) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(mk(b, 1'b0, 1'b1), 11, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
    repeat (5) @(negedge clock);
    checks++;
    if ({code_out, code_valid, code_break, code_ext, key_held, frame_err} !== 14'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {code_out, code_valid, code_break, code_ext, key_held, frame_err});
    end
    reset = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_make();
    int cv0;
    cv0 = cv_cnt;
    send_byte(8'h72);
    checks++; if (cv_cnt - cv0 !== 1) begin failures++; $display("FAIL make_count got=%0d exp=1", cv_cnt - cv0); end
    checks++; if ({cv_code, cv_brk, cv_ext} !== {8'h72, 1'b0, 1'b0}) begin
      failures++; $display("FAIL make_code got=%h/%b/%b exp=72/0/0", cv_code, cv_brk, cv_ext); end
    checks++; if (cv_keys !== 2'b01) begin failures++; $display("FAIL make_keys got=%b exp=01", cv_keys); end
    checks++; if (cv_cyc - drop_cyc !== DET_LAT + 1) begin
      failures++; $display("FAIL make_latency got=%0d exp=%0d", cv_cyc - drop_cyc, DET_LAT + 1); end
    checks++; if (fe_cnt !== 0) begin failures++; $display("FAIL make_no_err got=%0d exp=0", fe_cnt); end
  endtask

  task automatic test_ext_break();
    int cv0;
    cv0 = cv_cnt;
    send_byte(8'hE0);
    send_byte(8'h75);
    checks++; if (cv_cnt - cv0 !== 1) begin failures++; $display("FAIL ext_count got=%0d exp=1", cv_cnt - cv0); end
    checks++; if ({cv_code, cv_brk, cv_ext, cv_keys} !== {8'h75, 1'b0, 1'b1, 2'b11}) begin
      failures++; $display("FAIL ext_make got=%h/%b/%b/%b exp=75/0/1/11", cv_code, cv_brk, cv_ext, cv_keys); end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    checks++; if (cv_cnt - cv0 !== 2) begin failures++; $display("FAIL ext_brk_count got=%0d exp=2", cv_cnt - cv0); end
    checks++; if ({cv_code, cv_brk, cv_ext, cv_keys} !== {8'h75, 1'b1, 1'b1, 2'b01}) begin
      failures++; $display("FAIL ext_break got=%h/%b/%b/%b exp=75/1/1/01", cv_code, cv_brk, cv_ext, cv_keys); end
    checks++; if ({code_valid, code_out, code_break} !== {1'b0, 8'h75, 1'b1}) begin
      failures++; $display("FAIL hold_outputs got=%b/%h/%b exp=0/75/1", code_valid, code_out, code_break); end
  endtask

  task automatic test_parity();
    int cv0, fe0;
    send_byte(8'hF0);
    send_byte(8'h72);
    checks++; if ({cv_brk, cv_keys} !== {1'b1, 2'b00}) begin
      failures++; $display("FAIL release_72 got=%b/%b exp=1/00", cv_brk, cv_keys); end
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_bits(mk(8'h72, 1'b1, 1'b1), 11, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    checks++; if ({cv_cnt - cv0, fe_cnt - fe0} !== {32'd0, 32'd1}) begin
      failures++; $display("FAIL parity_err got cv=%0d fe=%0d exp cv=0 fe=1", cv_cnt - cv0, fe_cnt - fe0); end
    checks++; if (key_held !== 2'b00) begin failures++; $display("FAIL parity_keys got=%b exp=00", key_held); end
`else
    checks++; if ({cv_cnt - cv0, fe_cnt - fe0} !== {32'd1, 32'd0}) begin
      failures++; $display("FAIL parity_ignored got cv=%0d fe=%0d exp cv=1 fe=0", cv_cnt - cv0, fe_cnt - fe0); end
    checks++; if ({cv_code, key_held} !== {8'h72, 2'b01}) begin
      failures++; $display("FAIL parity_keys got=%h/%b exp=72/01", cv_code, key_held); end
`endif
    send_byte(8'hF0);
    send_byte(8'h72);
  endtask

  task automatic test_framing();
    int cv0, fe0;
    fe0 = fe_cnt;
    send_bits(11'h7FF, 1, 1'b0);
    checks++; if (fe_cnt - fe0 !== 1) begin failures++; $display("FAIL start_err got=%0d exp=1", fe_cnt - fe0); end
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_bits(mk(8'h75, 1'b0, 1'b0), 11, 1'b0);
    checks++; if ({cv_cnt - cv0, fe_cnt - fe0} !== {32'd0, 32'd1}) begin
      failures++; $display("FAIL stop_err got cv=%0d fe=%0d exp cv=0 fe=1", cv_cnt - cv0, fe_cnt - fe0); end
    send_byte(8'h75);
    checks++; if ({cv_cnt - cv0, cv_code, cv_keys} !== {32'd1, 8'h75, 2'b10}) begin
      failures++; $display("FAIL after_stop_err got=%0d/%h/%b exp=1/75/10", cv_cnt - cv0, cv_code, cv_keys); end
  endtask

  task automatic test_timeout();
    int fe0, cv0;
    fe0 = fe_cnt; cv0 = cv_cnt;
    send_bits(mk(8'h72, 1'b0, 1'b1), 5, 1'b0);
    repeat (T_OUT) @(negedge clock);
    checks++; if (fe_cnt - fe0 !== 1) begin failures++; $display("FAIL timeout_count got=%0d exp=1", fe_cnt - fe0); end
    checks++; if (fe_cyc - drop_cyc !== DET_LAT + T_OUT) begin
      failures++; $display("FAIL timeout_time got=%0d exp=%0d", fe_cyc - drop_cyc, DET_LAT + T_OUT); end
    send_byte(8'h72);
    checks++; if ({cv_cnt - cv0, cv_code, cv_brk, cv_keys} !== {32'd1, 8'h72, 1'b0, 2'b11}) begin
      failures++; $display("FAIL after_timeout got=%0d/%h/%b/%b exp=1/72/0/11", cv_cnt - cv0, cv_code, cv_brk, cv_keys); end
  endtask

  task automatic test_glitch();
    int fe0, cv0;
    send_byte(8'hF0);
    fe0 = fe_cnt; cv0 = cv_cnt;
    send_bits(mk(8'h75, 1'b0, 1'b1), 11, 1'b1);
    checks++; if ({cv_cnt - cv0, fe_cnt - fe0} !== {32'd1, 32'd0}) begin
      failures++; $display("FAIL glitch_counts got cv=%0d fe=%0d exp cv=1 fe=0", cv_cnt - cv0, fe_cnt - fe0); end
    checks++; if ({cv_code, cv_brk, cv_keys} !== {8'h75, 1'b1, 2'b01}) begin
      failures++; $display("FAIL glitch_code got=%h/%b/%b exp=75/1/01", cv_code, cv_brk, cv_keys); end
  endtask

  task automatic test_reset_midframe();
    int fe0, cv0;
    send_byte(8'hF0);
    send_bits(mk(8'h75, 1'b0, 1'b1), 4, 1'b0);
    fe0 = fe_cnt; cv0 = cv_cnt;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({code_out, code_valid, code_break, code_ext, key_held, frame_err} !== 14'h0) begin
      failures++;
      $display("FAIL midframe_reset got=%h exp=0", {code_out, code_valid, code_break, code_ext, key_held, frame_err});
    end
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (50) @(negedge clock);
    checks++; if ({cv_cnt - cv0, fe_cnt - fe0} !== {32'd0, 32'd0}) begin
      failures++; $display("FAIL midframe_quiet got cv=%0d fe=%0d exp 0/0", cv_cnt - cv0, fe_cnt - fe0); end
    send_byte(8'h72);
    checks++; if ({cv_cnt - cv0, cv_code, cv_brk, cv_ext, cv_keys} !== {32'd1, 8'h72, 1'b0, 1'b0, 2'b01}) begin
      failures++; $display("FAIL after_reset got=%0d/%h/%b/%b/%b exp=1/72/0/0/01", cv_cnt - cv0, cv_code, cv_brk, cv_ext, cv_keys); end
  endtask

  initial begin
    test_reset();
    test_make();
    test_ext_break();
    test_parity();
    test_framing();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
